// File: rtl/inv_twiddle_gen_pkg.sv
// Shared NTT constants and the twiddle-generator FSM state type.
package ntt_pkg;
  localparam int Q  = 65537;
  localparam int W  = 17;
  localparam int CW = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    MUL  = 2'd2
  } state_t;
endpackage

// File: rtl/inv_twiddle_gen_if.sv
// Control and output-stream bundle of the inverse twiddle generator.
// master = generator side, slave = controller/consumer side.
interface inv_twiddle_gen_if #(
  parameter int W  = ntt_pkg::W,
  parameter int CW = ntt_pkg::CW
) ();
  logic          start;
  logic [W-1:0]  base;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_value;
  logic [CW-1:0] out_index;
  logic          out_last;

  modport master (
    input  start, base, count, out_ready,
    output busy, done, out_valid, out_value, out_index, out_last
  );

  modport slave (
    output start, base, count, out_ready,
    input  busy, done, out_valid, out_value, out_index, out_last
  );
endinterface

// File: rtl/inv_twiddle_gen_mod_mult_seq.sv
// Sequential modular multiplier: p = a*b mod Q, MSB-first double-and-add,
// one bit of b per cycle (W cycles). Operands must already be < Q.
module mod_mult_seq #(
  parameter int Q = ntt_pkg::Q,
  parameter int W = ntt_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] p
);
  localparam int          CNT_W = $clog2(W);
  localparam logic [W:0]  QV    = (W+1)'(Q);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W-1);

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     r;

  // Inputs are < Q, so each one-bit-wider intermediate needs at most one subtract.
  function automatic logic [W-1:0] dbl_mod(input logic [W-1:0] x);
    logic [W:0] t;
    t = {x, 1'b0};
    if (t >= QV) t = t - QV;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= QV) t = t - QV;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] step(input logic [W-1:0] acc, input logic [W-1:0] m,
                                        input logic bit_i);
    logic [W-1:0] d;
    d = dbl_mod(acc);
    return bit_i ? add_mod(d, m) : d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (busy) begin
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start && !busy) begin
      a_r <= a;
      b_r <= b;
      r   <= '0;
    end else if (busy) begin
      r   <= step(r, a_r, b_r[W-1]);
      b_r <= {b_r[W-2:0], 1'b0};
    end
  end

  assign p = r;
endmodule

// File: rtl/inv_twiddle_gen.sv
// Inverse twiddle generator: streams base^k mod Q for k = 0..count-1.
// Define TWIDDLE_GEN_DUP_EN to emit every power as two identical beats.
module inv_twiddle_gen #(
  parameter int Q  = ntt_pkg::Q,
  parameter int W  = ntt_pkg::W,
  parameter int CW = ntt_pkg::CW
) (
  input logic              clk,
  input logic              rst,
  inv_twiddle_gen_if.master tw
);
  import ntt_pkg::*;

  localparam logic [W:0] QV = (W+1)'(Q);

  state_t        state, state_n;
  logic [W-1:0]  acc;
  logic [W-1:0]  base_r;
  logic [CW-1:0] k;
  logic [CW-1:0] count_r;
  logic [CW-1:0] last_k;
  logic          done_r, done_n;
  logic          mul_start, mul_busy, mul_done;
  logic [W-1:0]  mul_p;
  logic          second, final_pow;

  function automatic logic [W-1:0] reduce_q(input logic [W-1:0] x);
    logic [W:0] t;
    t = {1'b0, x};
    if (t >= QV) t = t - QV;
    return t[W-1:0];
  endfunction

  // count==0 wraps to last_k = 2^CW-1, giving the full 2^CW powers.
  assign last_k    = count_r - 1'b1;
  assign final_pow = (k == last_k);

`ifdef TWIDDLE_GEN_DUP_EN
  logic phase;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 phase <= 1'b0;
    else if (state != EMIT)                  phase <= 1'b0;
    else if (tw.out_ready)                   phase <= ~phase;
  end
  assign second = phase;
`else
  assign second = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mul_start = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: if (tw.start) state_n = EMIT;
      EMIT: begin
        if (tw.out_ready && second) begin
          if (final_pow) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n   = MUL;
            mul_start = !mul_busy;
          end
        end
      end
      MUL:     if (mul_done) state_n = EMIT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      base_r  <= '0;
      k       <= '0;
      count_r <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= done_n;
      if (state == IDLE && tw.start) begin
        base_r  <= reduce_q(tw.base);
        acc     <= W'(1);
        k       <= '0;
        count_r <= tw.count;
      end else if (state == MUL && mul_done) begin
        acc <= mul_p;
        k   <= k + 1'b1;
      end
    end
  end

  mod_mult_seq #(.Q(Q), .W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (acc),
    .b     (base_r),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  assign tw.busy      = (state != IDLE);
  assign tw.out_valid = (state == EMIT);
  assign tw.out_value = acc;
  assign tw.out_index = k;
  assign tw.out_last  = (state == EMIT) && final_pow && second;
  assign tw.done      = done_r;
endmodule

// File: tb/tb_inv_twiddle_gen.sv
// Self-checking bench for inv_twiddle_gen against a modular-power reference model.
// Honors TWIDDLE_GEN_DUP_EN (each power expected twice).
module tb_inv_twiddle_gen;
  localparam longint QM = 65537;
`ifdef TWIDDLE_GEN_DUP_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_twiddle_gen_if #(.W(17), .CW(7)) tw ();

  inv_twiddle_gen #(.Q(65537), .W(17), .CW(7)) dut (
    .clk (clk),
    .rst (rst),
    .tw  (tw.master)
  );

  typedef struct {
    logic [16:0] b;
    logic [6:0]  c;
    int          stall;
    bit          rnd;
    bit          poke;
    int          nexp;
    int          e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint pow_mod(input longint b, input int e);
    longint bm, v;
    bm = b % QM;
    v  = 1;
    for (int i = 0; i < e; i++) v = (v * bm) % QM;
    return v;
  endfunction

  task automatic run(input logic [16:0] b, input logic [6:0] c, input int stall, input bit rnd,
                     input bit poke, input int nexp, input int e0, input int e1, input int e2,
                     input int e3);
    int n, total, bidx, held, last_acc, done_cyc, fin_acc, dones, kk, budget;
    int e[4];
    logic [16:0] hv;
    logic [6:0]  hi;
    bit was_valid;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    n      = (c == 0) ? 128 : int'(c);
    total  = n * REP;
    budget = total * 40 + 100;
    @(negedge clk);
    tw.start = 1'b1; tw.base = b; tw.count = c; tw.out_ready = 1'b0;
    @(negedge clk);
    tw.start = 1'b0;
    chk("first_valid", tw.out_valid, 1);
    chk("busy_run", tw.busy, 1);
    bidx = 0; held = 0; dones = 0; fin_acc = -1; done_cyc = -1; last_acc = -1000;
    was_valid = 1'b0; hv = '0; hi = '0;
    for (int t = 0; t < budget; t++) begin
      if (poke && t == 2) begin
        tw.start = 1'b1; tw.base = 17'd7; tw.count = 7'd1;
      end else begin
        tw.start = 1'b0;
      end
      if (tw.done) begin
        dones++;
        done_cyc = cyc;
      end
      if (tw.out_valid) begin
        if (!was_valid && bidx > 0) chk("beat_gap_ge18", longint'(cyc - last_acc >= 18), 1);
        if (held > 0) begin
          chk("hold_value", tw.out_value, hv);
          chk("hold_index", tw.out_index, hi);
        end
        tw.out_ready = (held >= stall) && (!rnd || $urandom_range(0, 3) != 0);
        if (tw.out_ready) begin
          kk = bidx / REP;
          chk("value", tw.out_value, pow_mod(longint'(b), kk));
          chk("index", tw.out_index, kk);
          chk("last", tw.out_last, longint'(bidx == total - 1));
          if (kk < nexp) chk("spec_value", tw.out_value, e[kk]);
          last_acc = cyc;
          bidx++;
          held = 0;
          if (bidx == total) fin_acc = cyc;
        end else begin
          held++;
          hv = tw.out_value;
          hi = tw.out_index;
        end
      end else begin
        tw.out_ready = 1'($urandom_range(0, 1));
      end
      was_valid = tw.out_valid;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    tw.start     = 1'b0;
    tw.out_ready = 1'b0;
    chk("beats", bidx, total);
    chk("done_count", dones, 1);
    chk("done_latency", done_cyc - fin_acc, 1);
    chk("busy_after", tw.busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  tw.busy, 0);
    chk({tag, "_valid"}, tw.out_valid, 0);
    chk({tag, "_last"},  tw.out_last, 0);
    chk({tag, "_done"},  tw.done, 0);
    chk({tag, "_value"}, tw.out_value, 0);
    chk({tag, "_index"}, tw.out_index, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected fewer", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    vecs[0] = '{17'd2,      7'd4, 0, 1'b0, 1'b0, 4, 1, 2, 4, 8};
    vecs[1] = '{17'd32769,  7'd4, 0, 1'b0, 1'b0, 4, 1, 32769, 49153, 57345};
    vecs[2] = '{17'd65536,  7'd3, 0, 1'b0, 1'b0, 3, 1, 65536, 1, 0};
    vecs[3] = '{17'd65538,  7'd3, 0, 1'b0, 1'b0, 3, 1, 1, 1, 0};
    vecs[4] = '{17'd4,      7'd2, 0, 1'b0, 1'b0, 2, 1, 4, 0, 0};
    vecs[5] = '{17'd3,      7'd5, 5, 1'b0, 1'b0, 4, 1, 3, 9, 27};
    vecs[6] = '{17'd131071, 7'd6, 0, 1'b1, 1'b0, 2, 1, 65534, 0, 0};
    vecs[7] = '{17'd2,      7'd3, 0, 1'b0, 1'b1, 3, 1, 2, 4, 0};
    vecs[8] = '{17'd5,      7'd0, 0, 1'b0, 1'b0, 4, 1, 5, 25, 125};

    rst = 1'b1;
    tw.start = 1'b0; tw.base = '0; tw.count = '0; tw.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run(vecs[i].b, vecs[i].c, vecs[i].stall, vecs[i].rnd, vecs[i].poke, vecs[i].nexp,
          vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);

    for (int i = 0; i < 6; i++)
      run(17'($urandom_range(0, 131071)), 7'($urandom_range(1, 10)), $urandom_range(0, 3),
          1'b1, 1'b0, 0, 0, 0, 0, 0);

    // Abort mid-multiply, then confirm a fresh run is unaffected.
    @(negedge clk);
    tw.start = 1'b1; tw.base = 17'd4; tw.count = 7'd3; tw.out_ready = 1'b1;
    @(negedge clk);
    tw.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort_busy", tw.busy, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (tw.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_idle", tw.busy, 0);
    tw.out_ready = 1'b0;
    run(17'd4, 7'd2, 0, 1'b0, 1'b0, 2, 1, 4, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
